// File: rtl/instr_encode.sv
// instr_encode: packs decoded LEGv8 fields (opcode, Rm, shamt, DT_address, Rn, Rd) into 32-bit
// instruction words and streams them with byte addresses through a 2-entry output buffer.
// The buffer holds a head entry (driven on out_*) and a tail entry (filled only when the head is
// stalled). Each accepted word advances a program address and an acceptance count. Once DEPTH
// words have been accepted, no further input is taken until restart or reset.
// Optional feature macro: OPCODE_CHECK_EN. When it is defined, opcodes outside the legal set
// complete the handshake but are dropped, and they set the sticky err flag.
module instr_encode #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned CNT_W     = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        restart,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] in_opcode,
  input  logic [4:0]  in_rm,
  input  logic [5:0]  in_shamt,
  input  logic [8:0]  in_address,
  input  logic [4:0]  in_rn,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        done,
  output logic        err
);

  localparam logic [10:0] OpStur = 11'h7C0;
  localparam logic [10:0] OpLdur = 11'h7C2;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} buf_state_e;

  buf_state_e        state_q;
  logic [31:0]       head_instr_q, head_addr_q;
  logic [31:0]       tail_instr_q, tail_addr_q;
  logic [31:0]       addr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [31:0] entry_d;
  logic        is_dfmt;
  logic        legal;
  logic        in_fire, out_fire, push;
  logic        cnt_full;

  // Pack the incoming field tuple; D-format ignores Rm and shamt.
  always_comb begin
    is_dfmt = (in_opcode == OpStur) || (in_opcode == OpLdur);
    if (is_dfmt) begin
      entry_d = {in_opcode, in_address, 2'b00, in_rn, in_rd};
    end else begin
      entry_d = {in_opcode, in_rm, in_shamt, in_rn, in_rd};
    end
  end

`ifdef OPCODE_CHECK_EN
  logic err_q;

  // Legal opcode set: ADD, SUB, AND, ORR, STUR, LDUR.
  always_comb begin
    unique case (in_opcode)
      11'h458, 11'h658, 11'h450, 11'h550, OpStur, OpLdur: legal = 1'b1;
      default:                                            legal = 1'b0;
    endcase
  end

  // Sticky illegal-opcode flag; only reset clears it, restart leaves it alone.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (in_fire && !legal) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign legal = 1'b1;
  assign err   = 1'b0;
`endif

  // Handshake decode; in_ready depends only on state, count, restart and reset, never on
  // out_ready, so a full buffer refuses input even in a cycle where it is popped.
  always_comb begin
    cnt_full  = (cnt_q >= CNT_W'(DEPTH));
    in_ready  = reset_n && !restart && (state_q != StTwo) && !cnt_full;
    out_valid = (state_q != StEmpty);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    push      = in_fire && legal;
    done      = cnt_full && (state_q == StEmpty);
    out_instr = head_instr_q;
    out_addr  = head_addr_q;
  end

  // Buffer FSM plus program address / count; restart overrides every transfer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StEmpty;
      head_instr_q <= 32'h0;
      head_addr_q  <= 32'h0;
      tail_instr_q <= 32'h0;
      tail_addr_q  <= 32'h0;
      addr_q       <= BASE_ADDR;
      cnt_q        <= '0;
    end else if (restart) begin
      state_q <= StEmpty;
      addr_q  <= BASE_ADDR;
      cnt_q   <= '0;
    end else begin
      if (push) begin
        addr_q <= addr_q + 32'd4;
        cnt_q  <= cnt_q + 1'b1;
      end
      case (state_q)
        StEmpty: begin
          if (push) begin
            head_instr_q <= entry_d;
            head_addr_q  <= addr_q;
            state_q      <= StOne;
          end
        end
        StOne: begin
          if (push && out_fire) begin
            head_instr_q <= entry_d;
            head_addr_q  <= addr_q;
          end else if (push) begin
            tail_instr_q <= entry_d;
            tail_addr_q  <= addr_q;
            state_q      <= StTwo;
          end else if (out_fire) begin
            state_q <= StEmpty;
          end
        end
        StTwo: begin
          if (out_fire) begin
            head_instr_q <= tail_instr_q;
            head_addr_q  <= tail_addr_q;
            state_q      <= StOne;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode.sv
// Directed bench for instr_encode (DEPTH = 4) with hand-computed expected words and addresses.
module tb_instr_encode;

  logic        clk = 1'b0;
  logic        reset_n, restart, in_valid, in_ready, out_valid, out_ready, done, err;
  logic [10:0] in_opcode;
  logic [4:0]  in_rm, in_rn, in_rd;
  logic [5:0]  in_shamt;
  logic [8:0]  in_address;
  logic [31:0] out_instr, out_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_encode #(
    .BASE_ADDR(32'h0),
    .DEPTH    (4),
    .CNT_W    (11)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rm     (in_rm),
    .in_shamt  (in_shamt),
    .in_address(in_address),
    .in_rn     (in_rn),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [10:0] op, input logic [4:0] rm, input logic [5:0] sh,
                            input logic [8:0] ad, input logic [4:0] rn, input logic [4:0] rd);
    in_opcode  = op;
    in_rm      = rm;
    in_shamt   = sh;
    in_address = ad;
    in_rn      = rn;
    in_rd      = rd;
  endtask

  initial begin
    reset_n   = 1'b0;
    restart   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_fields(11'h0, 5'd0, 6'd0, 9'd0, 5'd0, 5'd0);
    tick();
    tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_addr", out_addr, 32'h0);
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // ADD X3,X1,X2
    set_fields(11'h458, 5'd2, 6'd0, 9'd0, 5'd1, 5'd3);
    in_valid = 1'b1;
    tick();
    check("add_valid", {31'b0, out_valid}, 32'd1);
    check("add_instr", out_instr, 32'h8B02_0023);
    check("add_addr", out_addr, 32'h0);
    // LDUR X5,[X2,#8] with junk Rm/shamt, accepted in the same cycle the ADD pops
    set_fields(11'h7C2, 5'd31, 6'd63, 9'd8, 5'd2, 5'd5);
    out_ready = 1'b1;
    tick();
    check("ldur_instr", out_instr, 32'hF840_8045);
    check("ldur_addr", out_addr, 32'h4);
    in_valid = 1'b0;
    tick();
    check("drain_empty", {31'b0, out_valid}, 32'd0);
    restart = 1'b1;
    #1;
    check("restart_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    restart = 1'b0;

    // Backpressure: three tuples offered with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_fields(11'h458, 5'd0, 6'd0, 9'd0, 5'd0, 5'd10);
    tick();
    set_fields(11'h458, 5'd0, 6'd0, 9'd0, 5'd0, 5'd11);
    tick();
    set_fields(11'h458, 5'd0, 6'd0, 9'd0, 5'd0, 5'd12);
    #1;
    check("bp_full_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
    check("bp_hold_instr", out_instr, 32'h8B00_000A);
    check("bp_hold_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    tick();
    check("bp_second_instr", out_instr, 32'h8B00_000B);
    check("bp_second_addr", out_addr, 32'h4);
    tick();
    check("bp_third_instr", out_instr, 32'h8B00_000C);
    check("bp_third_addr", out_addr, 32'h8);
    in_valid = 1'b0;
    tick();
    check("bp_drained", {31'b0, out_valid}, 32'd0);
    restart = 1'b1;
    tick();
    restart = 1'b0;

    // Depth limit (DEPTH = 4): six tuples offered with out_ready high
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_fields(11'h550, 5'd0, 6'd0, 9'd0, 5'd0, 5'(k));
      tick();
      check("depth_addr", out_addr, 32'(4 * k));
      check("depth_instr", out_instr, 32'hAA00_0000 | 32'(k));
    end
    check("depth_in_ready_low", {31'b0, in_ready}, 32'd0);
    check("depth_done_early", {31'b0, done}, 32'd0);
    tick();
    check("depth_done", {31'b0, done}, 32'd1);
    check("depth_empty", {31'b0, out_valid}, 32'd0);
    tick();
    tick();
    check("depth_no_extra", {31'b0, out_valid}, 32'd0);
    check("depth_still_blocked", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    restart  = 1'b1;
    tick();
    restart  = 1'b0;
    check("restart_done_clr", {31'b0, done}, 32'd0);
    in_valid = 1'b1;
    set_fields(11'h458, 5'd0, 6'd0, 9'd0, 5'd0, 5'd9);
    tick();
    in_valid = 1'b0;
    check("restart_addr", out_addr, 32'h0);
    tick();

    // Reset while the buffer holds two entries
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("mid_full", {31'b0, in_ready}, 32'd0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mid_rst_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;

    // Unlisted opcode 0x123 followed by SUB X7,X6,X5
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_fields(11'h123, 5'd0, 6'd0, 9'd0, 5'd0, 5'd0);
    tick();
`ifdef OPCODE_CHECK_EN
    check("chk_err_set", {31'b0, err}, 32'd1);
    check("chk_dropped", {31'b0, out_valid}, 32'd0);
    set_fields(11'h658, 5'd5, 6'd0, 9'd0, 5'd6, 5'd7);
    tick();
    in_valid = 1'b0;
    check("chk_sub_instr", out_instr, 32'hCB05_00C7);
    check("chk_sub_addr", out_addr, 32'h0);
    check("chk_err_sticky", {31'b0, err}, 32'd1);
`else
    check("nochk_err", {31'b0, err}, 32'd0);
    check("nochk_instr", out_instr, 32'h2460_0000);
    check("nochk_addr", out_addr, 32'h0);
    set_fields(11'h658, 5'd5, 6'd0, 9'd0, 5'd6, 5'd7);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("nochk_sub_instr", out_instr, 32'hCB05_00C7);
    check("nochk_sub_addr", out_addr, 32'h4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encode.md
# instr_encode

Packs decoded LEGv8 instruction fields (opcode, registers, address/shamt) into 32-bit `INSTR_LEN` instruction words and streams them, with byte addresses, toward instruction-memory load logic. It performs the inverse of the decode-stage field split and is used by the program loader and by self-checking benches. It has a valid/ready input, a 2-entry output buffer, and a program-address generator with a fixed program depth.

## Interface
- `BASE_ADDR`, 0: byte address of the first emitted instruction; multiple of 4.
- `DEPTH`, 64: maximum instructions per program; 1..1024.
- `CNT_W`, 11: width of the accepted-count register; must hold `DEPTH`.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `restart`  in  1  synchronous clear of the address and count; the buffer is flushed.
- `in_valid`  in  1  field tuple valid.
- `in_ready`  out  1  block can accept a tuple.
- `in_opcode`  in  11  instruction bits [31:21].
- `in_rm`  in  5  R-format Rm.
- `in_shamt`  in  6  R-format shamt.
- `in_address`  in  9  D-format DT_address.
- `in_rn`  in  5  Rn.
- `in_rd`  in  5  Rd / Rt.
- `out_valid`  out  1  head buffer entry valid.
- `out_ready`  in  1  consumer takes the head entry.
- `out_instr`  out  `INSTR_LEN`  packed instruction.
- `out_addr`  out  32  byte address of `out_instr`.
- `done`  out  1  `DEPTH` instructions accepted and buffer empty.
- `err`  out  1  sticky illegal-opcode flag. Driven 0 when `OPCODE_CHECK_EN` is not defined.

## Operation
- Format selection: opcode 11'h7C0 (STUR) or 11'h7C2 (LDUR) selects D-format; every other opcode selects R-format.
- R-format packing: {opcode, rm, shamt, rn, rd}.
- D-format packing: {opcode, address, 2'b00, rn, rd}. `in_rm` and `in_shamt` are ignored.
- Input transfer: occurs when `in_valid && in_ready`.
  - The packed word is written to the buffer tail together with the current `addr_q`.
  - Then `addr_q += 4` (32-bit wrap) and `cnt_q += 1`.
- Buffer FSM states:
  - EMPTY → ONE on an input transfer.
  - ONE → TWO on an input transfer without an output transfer.
  - ONE → EMPTY on an output transfer without an input transfer.
  - ONE → ONE when both transfers occur in the same cycle.
  - TWO → ONE on an output transfer. No input is possible in TWO.
- Output transfer: occurs when `out_valid && out_ready`; it pops the head entry.
- `in_ready` = (state != TWO) && (`cnt_q` < `DEPTH`) && !`restart`. It must not depend on `out_ready` combinationally.
- `done` = (`cnt_q` == `DEPTH`) && state == EMPTY.
- `restart` has priority over all transfers: state → EMPTY, `addr_q` → `BASE_ADDR`, `cnt_q` → 0. `err` is NOT cleared.

## Timing
- Reset values: `out_valid`=0, `out_instr`=0, `out_addr`=0, `in_ready`=0 during reset and 1 on the first cycle after it, `done`=0, `err`=0, `addr_q`=`BASE_ADDR`, `cnt_q`=0, state EMPTY.
- Latency: a tuple accepted at edge N appears on `out_*` after edge N, with `out_valid` visible in cycle N+1.
- Throughput: sustained 1 instruction per cycle while `out_ready` is held high.
- Output stability: while `out_valid && !out_ready`, `out_instr` and `out_addr` hold stable.
- Reset asserted mid-stream discards both buffer entries on that edge; no partial output is produced.
- After `DEPTH` acceptances, `in_ready` stays 0 until `restart` or reset. The buffer still drains normally.

## Configuration
- `OPCODE_CHECK_EN` defined:
  - Legal opcodes are 458 (ADD), 658 (SUB), 450 (AND), 550 (ORR), 7C0, 7C2.
  - Any other opcode still completes the input handshake but is dropped.
  - A dropped tuple is not buffered, does not advance `addr_q` or `cnt_q`, and sets `err` on the next edge. `err` clears only on reset.
- `OPCODE_CHECK_EN` not defined: every opcode is packed per the format rule and `err` is tied to 0.

## Test plan
- ADD X3,X1,X2: opcode 458, rm 2, shamt 0, rn 1, rd 3 → `out_instr` 0x8B020023, `out_addr` 0x0.
- LDUR X5,[X2,#8]: opcode 7C2, address 8, rn 2, rd 5, rm 31 (ignored) → `out_instr` 0xF8408045, `out_addr` 0x4.
- Backpressure: hold `out_ready`=0 and offer 3 tuples → exactly 2 accepted; `in_ready` low while the buffer is full. Releasing `out_ready` yields in-order output with addresses 0x0, 0x4, 0x8.
- Depth limit with `DEPTH`=4: stream 6 tuples with `out_ready`=1 → 4 emitted; `in_ready`=0 afterward; `done`=1 one cycle after the last pop. `restart` → next `out_addr` is 0x0.
- Reset mid-stream: drop `reset_n` for 1 cycle while in TWO → `out_valid`=0 and `done`=0; the next accepted tuple gets `out_addr` 0x0.
- With `OPCODE_CHECK_EN` defined: offer opcode 0x123 and then SUB → `err`=1; only the SUB is emitted, as 0xCB..., at `out_addr` 0x0.
